// File: rtl/hls2x4_2_dot_acc.sv
// Dot-product accumulator behind the HLS2x4_2 multiplier: sums TERMS signed
// products per row and presents one saturated result per row on a valid/ready register.
module hls2x4_2_dot_acc #(
  parameter int unsigned DIN_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH  = 20,
  parameter int unsigned DOUT_WIDTH = 16,
  parameter int unsigned TERMS      = 4,
  parameter int unsigned ROWS       = 2,
  localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic [ROW_W-1:0]      dout_row,
  output logic                  dout_last,
  output logic                  dout_sat,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int unsigned TERM_W = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam int unsigned HI_W   = ACC_WIDTH - DOUT_WIDTH + 1;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [TERM_W-1:0]           term_q, term_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [DOUT_WIDTH-1:0]       dout_q, dout_d;
  logic [ROW_W-1:0]            dout_row_q, dout_row_d;
  logic                        dout_last_q, dout_last_d;
  logic                        dout_sat_q, dout_sat_d;
  logic                        dout_valid_q, dout_valid_d;

  logic                        final_term;
  logic                        in_xfer;
  logic                        out_xfer;
  logic signed [ACC_WIDTH-1:0] din_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [HI_W-1:0]             sum_hi;
  logic                        sum_ovf;
  logic [DOUT_WIDTH-1:0]       sum_sat;

  // Only the final term may stall, and only when it would overwrite an undrained result.
  assign final_term = (term_q == TERM_W'(TERMS - 1));
  assign din_ready  = !(final_term && dout_valid_q && !dout_ready);
  assign in_xfer    = din_valid && din_ready;
  assign out_xfer   = dout_valid_q && dout_ready;

  // Sum fits DOUT_WIDTH exactly when every bit from the DOUT sign bit upward agrees.
  assign din_ext = ACC_WIDTH'($signed(din));
  assign sum     = acc_q + din_ext;
  assign sum_hi  = sum[ACC_WIDTH-1:DOUT_WIDTH-1];
  assign sum_ovf = !((&sum_hi) || !(|sum_hi));
  assign sum_sat = sum_ovf ? (sum[ACC_WIDTH-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                               : {1'b0, {(DOUT_WIDTH-1){1'b1}}})
                           : sum[DOUT_WIDTH-1:0];

  always_comb begin
    acc_d        = acc_q;
    term_d       = term_q;
    row_d        = row_q;
    dout_d       = dout_q;
    dout_row_d   = dout_row_q;
    dout_last_d  = dout_last_q;
    dout_sat_d   = dout_sat_q;
    dout_valid_d = dout_valid_q;

    if (out_xfer) begin
      dout_valid_d = 1'b0;
    end

    if (in_xfer) begin
      if (final_term) begin
        dout_d       = sum_sat;
        dout_sat_d   = sum_ovf;
        dout_row_d   = row_q;
        dout_last_d  = (row_q == ROW_W'(ROWS - 1));
        dout_valid_d = 1'b1;
        acc_d        = '0;
        term_d       = '0;
        row_d        = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        acc_d  = sum;
        term_d = term_q + TERM_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q        <= '0;
      term_q       <= '0;
      row_q        <= '0;
      dout_q       <= '0;
      dout_row_q   <= '0;
      dout_last_q  <= 1'b0;
      dout_sat_q   <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      term_q       <= term_d;
      row_q        <= row_d;
      dout_q       <= dout_d;
      dout_row_q   <= dout_row_d;
      dout_last_q  <= dout_last_d;
      dout_sat_q   <= dout_sat_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_row   = dout_row_q;
  assign dout_last  = dout_last_q;
  assign dout_sat   = dout_sat_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_hls2x4_2_dot_acc.sv
// Bench for hls2x4_2_dot_acc: integer reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hls2x4_2_dot_acc;

  localparam int unsigned TERMS = 4;
  localparam int unsigned ROWS  = 2;

  logic        ap_clk;
  logic        ap_rst;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] dout;
  logic [0:0]  dout_row;
  logic        dout_last;
  logic        dout_sat;
  logic        dout_valid;
  logic        dout_ready;

  int n_cmp = 0;
  int n_bad = 0;

  hls2x4_2_dot_acc #(
    .DIN_WIDTH(16), .ACC_WIDTH(20), .DOUT_WIDTH(16), .TERMS(TERMS), .ROWS(ROWS)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_row(dout_row), .dout_last(dout_last),
    .dout_sat(dout_sat), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer accumulation and clamping.
  int m_acc, m_term, m_row, m_dout, m_drow, m_last, m_sat, m_valid;

  function automatic int m_ready();
    return (m_term == TERMS - 1 && m_valid == 1 && !dout_ready) ? 0 : 1;
  endfunction

  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      m_acc = 0; m_term = 0; m_row = 0;
      m_dout = 0; m_drow = 0; m_last = 0; m_sat = 0; m_valid = 0;
    end else begin
      int s;
      bit in_x, out_x;
      in_x  = din_valid && (m_ready() == 1);
      out_x = (m_valid == 1) && dout_ready;
      if (out_x) m_valid = 0;
      if (in_x) begin
        s = m_acc + int'($signed(din));
        if (m_term == TERMS - 1) begin
          if (s > 32767)       begin m_dout = 32767;  m_sat = 1; end
          else if (s < -32768) begin m_dout = -32768; m_sat = 1; end
          else                 begin m_dout = s;      m_sat = 0; end
          m_drow  = m_row;
          m_last  = (m_row == ROWS - 1) ? 1 : 0;
          m_valid = 1;
          m_acc   = 0;
          m_term  = 0;
          m_row   = (m_row + 1) % ROWS;
        end else begin
          m_acc  = s;
          m_term = m_term + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge ap_clk) begin
    chk("din_ready",  int'(din_ready),     m_ready());
    chk("dout_valid", int'(dout_valid),    m_valid);
    chk("dout",       int'($signed(dout)), m_dout);
    chk("dout_row",   int'(dout_row),      m_drow);
    chk("dout_last",  int'(dout_last),     m_last);
    chk("dout_sat",   int'(dout_sat),      m_sat);
  end

  // Present one product and hold it until accepted; leaves din_valid high.
  task automatic send(input int v);
    bit acc;
    int n;
    din       = 16'(v);
    din_valid = 1'b1;
    n = 0;
    do begin
      @(negedge ap_clk);
      acc = din_ready;
      @(posedge ap_clk);
      #1;
      n++;
    end while (!acc && n < 50);
    chk("din_accept", int'(acc), 1);
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
    din_valid = 1'b0;
  endtask

  task automatic chk_out(input string nm, input int v, input int row, input int last, input int sat);
    chk({nm, "_dout"},  int'($signed(dout)), v);
    chk({nm, "_row"},   int'(dout_row),      row);
    chk({nm, "_last"},  int'(dout_last),     last);
    chk({nm, "_sat"},   int'(dout_sat),      sat);
    chk({nm, "_valid"}, int'(dout_valid),    1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
    #1 ap_rst = 1'b1;
    #2;
    chk("rst_din_ready",  int'(din_ready),  1);
    chk("rst_dout",       int'(dout),       0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_dout_sat",   int'(dout_sat),   0);
    #9 ap_rst = 1'b0;
    @(posedge ap_clk); #1;

    // Basic pass
    send4(1, 2, 3, 4);
    chk_out("basic0", 10, 0, 0, 0);
    send4(-5, -5, -5, -5);
    chk_out("basic1", -20, 1, 1, 0);

    // Saturation and in-range boundary
    send4(16000, 16000, 16000, 16000);
    chk_out("satpos", 32767, 0, 0, 1);
    send4(-16000, -16000, -16000, -16000);
    chk_out("satneg", -32768, 1, 1, 1);
    send4(8191, 8191, 8191, 8191);
    chk_out("nosat", 32764, 0, 0, 0);
    @(posedge ap_clk); #1;

    // Backpressure on the final term
    dout_ready = 1'b0;
    send4(1, 2, 3, 4);
    chk_out("bp_first", 10, 1, 1, 0);
    send(1); send(1); send(1);
    din = 16'(1);
    din_valid = 1'b1;
    repeat (3) begin
      @(negedge ap_clk);
      chk("bp_stall_ready", int'(din_ready), 0);
      chk("bp_hold_dout", int'($signed(dout)), 10);
    end
    @(posedge ap_clk); #1;
    dout_ready = 1'b1;
    @(posedge ap_clk); #1;
    din_valid = 1'b0;
    chk_out("bp_release", 4, 0, 0, 0);

    // Output drain and final-term load in the same cycle
    dout_ready = 1'b0;
    send(3); send(3); send(3);
    chk("sim_hold_valid", int'(dout_valid), 1);
    dout_ready = 1'b1;
    send(3);
    din_valid = 1'b0;
    chk_out("simul", 12, 1, 1, 0);

    // Asynchronous reset mid-row
    send(7); send(7);
    din_valid = 1'b0;
    #2 ap_rst = 1'b1;
    #1;
    chk("arst_dout",       int'(dout),       0);
    chk("arst_dout_valid", int'(dout_valid), 0);
    chk("arst_din_ready",  int'(din_ready),  1);
    #2 ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    send4(1, 1, 1, 1);
    chk_out("post_rst", 4, 0, 0, 0);

    // din_valid gaps
    begin
      bit vpat[7] = '{1, 0, 0, 1, 0, 1, 1};
      int k = 0;
      int vals[4] = '{2, 3, 4, 5};
      for (int i = 0; i < 7; i++) begin
        din_valid = vpat[i];
        if (vpat[i]) begin din = 16'(vals[k]); k++; end
        else din = 16'($urandom);
        @(posedge ap_clk); #1;
      end
      din_valid = 1'b0;
      chk_out("gaps", 14, 1, 1, 0);
    end

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      din_valid  = ($urandom % 4) != 0;
      dout_ready = ($urandom % 4) != 0;
      if ($urandom % 2) din = 16'($urandom);
      else              din = 16'($urandom_range(0, 40) - 20);
      @(posedge ap_clk); #1;
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hls2x4_2_dot_acc.md
# hls2x4_2_dot_acc

Downstream stage of the HLS2x4_2 signed 16x16 multiplier. Consumes the stream of truncated 16-bit signed products and accumulates TERMS consecutive products into one dot-product result per matrix row. Emits ROWS results per 2x4 matrix-vector pass. Each result is saturated to DOUT_WIDTH and presented on a valid/ready output register.

## Interface
- DIN_WIDTH, 16, signed product width from the multiplier
- ACC_WIDTH, 20, internal signed accumulator width; must be ≥ DIN_WIDTH + clog2(TERMS)
- DOUT_WIDTH, 16, signed result width after saturation
- TERMS, 4, products summed per result (row length)
- ROWS, 2, results per pass (row count)

- ap_clk  in  1  clock, all state on rising edge
- ap_rst  in  1  asynchronous, active-high reset
- din  in  DIN_WIDTH  signed product
- din_valid  in  1  din holds a product
- din_ready  out  1  block accepts din this cycle
- dout  out  DOUT_WIDTH  signed saturated dot product
- dout_row  out  max(1,clog2(ROWS))  row index of dout
- dout_last  out  1  dout is row ROWS-1, the end of a pass
- dout_sat  out  1  dout was clipped
- dout_valid  out  1  output register holds a result
- dout_ready  in  1  consumer takes dout this cycle

## Operation
- Input transfer occurs when din_valid && din_ready. Output transfer occurs when dout_valid && dout_ready.
- State:
  - acc (ACC_WIDTH, signed)
  - term counter 0..TERMS-1
  - row counter 0..ROWS-1
  - output register: dout, dout_row, dout_last, dout_sat, dout_valid
- On input transfer with term < TERMS-1:
  - acc ← acc + sign-extended din
  - term ← term+1
  - output register untouched
- On input transfer with term == TERMS-1 (final term):
  - sum = acc + sign-extended din
  - dout ← sat(sum); dout_sat ← (sum was out of range)
  - dout_row ← row; dout_last ← (row == ROWS-1)
  - dout_valid ← 1; acc ← 0; term ← 0
  - row ← row+1, wrapping ROWS-1 → 0
- Saturation: sum > 2^(DOUT_WIDTH-1)-1 gives 32767; sum < -2^(DOUT_WIDTH-1) gives -32768; otherwise sum truncated to DOUT_WIDTH (exact).
- Accumulation never overflows ACC_WIDTH at the defaults: max |sum| is 4·32768 = 131072 < 2^19.
- din_ready = !(term == TERMS-1 && dout_valid && !dout_ready). Only the final term can stall, and only when it would overwrite an undrained result. Non-final terms are always accepted.
- Output transfer without a simultaneous final-term transfer: dout_valid ← 0. Data fields hold their last value.
- Simultaneous output transfer and final-term transfer: the new result loads; dout_valid stays 1.
- ap_rst (any time, including mid-row or while dout_valid): acc, term, row ← 0. All outputs ← 0. The partial sum is discarded with no result emitted. The next accepted product starts row 0, term 0.
- No state machine beyond the term/row counters and dout_valid (states: EMPTY = !dout_valid, FULL = dout_valid).

## Timing
- Reset values: din_ready=1; dout=0, dout_row=0, dout_last=0, dout_sat=0, dout_valid=0.
- Latency: dout_valid rises on the clock edge that accepts the final term, so the result is visible the cycle after the final din transfer.
- Throughput: 1 product/cycle sustained with dout_ready=1. This gives 1 result per TERMS cycles and 1 full pass per ROWS·TERMS products.
- din_ready depends combinationally on dout_ready, term and dout_valid. There is no combinational path from din to any output.
- din_valid gaps do not disturb acc, term or row.

## Test plan
- Basic pass, dout_ready=1:
  - din 1,2,3,4 back-to-back → dout=10, row=0, last=0, sat=0, one cycle after the 4th term.
  - Then -5,-5,-5,-5 → dout=-20, row=1, last=1.
- Saturation:
  - 4×16000 → sum 64000 → dout=32767, sat=1.
  - 4×(-16000) → dout=-32768, sat=1.
  - 4×8191 → dout=32764, sat=0.
- Backpressure with dout_ready=0 after the first result (10):
  - Next row's terms 1,1,1 accepted.
  - 4th term sees din_ready=0 and is held; dout stays 10.
  - Raise dout_ready → 10 transfers and the 4th term is accepted the same cycle; dout=4 next cycle.
- Simultaneous events: dout_valid=1, dout_ready=1 on the cycle the final term transfers → dout_valid remains 1 and dout updates with no bubble.
- Reset mid-row:
  - Feed 7,7, then pulse ap_rst asynchronously (off clock edge) → all outputs 0 immediately.
  - Then 1,1,1,1 → dout=4, row=0.
- Input gaps: din_valid toggled 1,0,0,1,0,1,1 carrying 2,3,4,5 → a single result of 14 after the last transfer.
